imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//   Write-side counterpart of the instruction memory: receives a program image as a byte
//   stream from the UART receiver and writes 32-bit words into the instruction RAM.
//   Holds the CPU in reset (cpu_hold) until a frame is loaded and its checksum verifies.
//   Sits between uart_rx and the instruction RAM write port.
//   The CPU reads the RAM through Address[9:2], so the RAM is word-indexed.
// PARAMETERS
//   ADDR_WIDTH      8          word-index width; image wraps modulo 2**ADDR_WIDTH words
//   SYNC_BYTE       8'hA5      frame start marker
//   TIMEOUT_CYCLES  1000000    max idle cycles between bytes inside a frame
// PORTS
//   clk         in   1           system clock
//   reset       in   1           asynchronous, active-high reset
//   rx_data     in   8           byte from UART receiver
//   rx_valid    in   1           one-cycle strobe: rx_data valid
//   imem_we     out  1           RAM write enable, one-cycle pulse per word
//   imem_addr   out  32          RAM byte address: {word_idx, 2'b00}; upper bits 0
//   imem_wdata  out  32          assembled word
//   cpu_hold    out  1           1 = CPU held in reset
//   load_done   out  1           one-cycle pulse: frame accepted, checksum OK
//   load_error  out  1           sticky: checksum mismatch or timeout; cleared at next SYNC
// BEHAVIOUR
//   Reset values
//     state=IDLE, cpu_hold=1, all other outputs 0, word_idx=0, csum=0, byte_cnt=0.
//   Frame format
//     SYNC, N, 4*N payload bytes (big-endian words, MSB first), CSUM.
//     N=0 means 256 words. CSUM = XOR of all payload bytes.
//   States
//     IDLE: rx_valid && rx_data==SYNC -> COUNT; set cpu_hold=1, clear load_error,
//       word_idx=0, csum=0, byte_cnt=0. Any other byte is ignored.
//     COUNT: next byte latched as N -> DATA.
//     DATA: shift byte into the word register, XOR it into csum, byte_cnt++.
//       On the 4th byte: next cycle imem_we=1 with imem_addr={word_idx,2'b00} and
//       imem_wdata=word; then word_idx++ and words_left--.
//       -> CSUM when words_left reaches 0.
//       A byte equal to SYNC inside DATA is payload, not a restart.
//     CSUM: byte==csum -> load_done pulse, cpu_hold=0, -> IDLE.
//       Mismatch -> load_error=1, cpu_hold stays 1, -> IDLE.
//       Words already written are not rolled back.
//   Write latency: imem_we asserts exactly 1 cycle after the strobe of each 4th byte.
//     Back-to-back rx_valid every cycle is legal: a write and a new byte can coincide.
//   Timeout: counter resets on every rx_valid; runs only in COUNT, DATA and CSUM.
//     At TIMEOUT_CYCLES -> load_error=1, -> IDLE, no write.
//     A partial word is discarded.
//     If rx_valid and expiry fall in the same cycle, the byte wins and the counter resets.
//   Reload: after a successful load, a new SYNC re-asserts cpu_hold the cycle after the
//     SYNC strobe, then proceeds as above.
//   Reset mid-frame: everything returns to reset values; any partial write is abandoned.
//     imem_we must never be high while reset=1.
//   word_idx wraps to 0 past 2**ADDR_WIDTH-1.
// STRUCTURE
//   Shared include loader_defs.vh: state encodings (IDLE, COUNT, DATA, CSUM),
//     SYNC_BYTE default, frame-format constants.
//   One natural sub-module: loader_timeout (loadable down-counter: kick, enable, expired).
//   Byte assembly, checksum and FSM remain in this module.
// TESTING
//   1. Frame A5,01,20,1d,04,00,CSUM=39 -> one write: addr 0, data 32'h201d0400;
//      load_done pulse; cpu_hold 1->0.
//   2. Frame of 3 words with CSUM flipped -> 3 writes at addr 0,4,8; load_error=1;
//      cpu_hold stays 1; no load_done.
//   3. SYNC, N=2, 5 payload bytes, then silence for TIMEOUT_CYCLES -> exactly 1 write;
//      load_error=1; state IDLE.
//   4. N=0 with ADDR_WIDTH=8 -> 256 writes, last addr 32'h3FC; byte A5 inside payload is
//      written as data; valid CSUM -> load_done.
//   5. Bytes strobed every cycle -> imem_we exactly 1 cycle after every 4th byte;
//      no byte dropped.
//   6. Assert reset mid-DATA -> imem_we=0 immediately, cpu_hold=1; a following good frame
//      loads from addr 0.

Source files
------------

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, frame constants
// and the word-count decode for the frame header.
package imem_uart_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DATA  = 2'd2,
    S_CSUM  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_DEF       = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         MAX_WORDS      = 256;

  // A header of zero encodes the largest frame (256 words).
  function automatic logic [8:0] frame_words(input logic [7:0] n);
    return (n == 8'd0) ? 9'(MAX_WORDS) : {1'b0, n};
  endfunction

endpackage

// File: rtl/imem_uart_loader_timeout.sv
// Inter-byte idle watchdog: reloads on every kick (or while disabled) and
// flags expiry once CYCLES idle cycles have elapsed with the count enabled.
module loader_timeout #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= CW'(CYCLES);
    else if (kick || !en)    cnt <= CW'(CYCLES);
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/imem_uart_loader.sv
// UART program-image loader: assembles big-endian words from a framed byte
// stream, writes them into the instruction RAM and releases the CPU on a good checksum.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEF,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [8:0]            words_left;
  logic [7:0]            csum;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_sh;
  logic                  tmo;

  logic start, latch_n, take, word_done, frame_ok, frame_bad;

  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .kick    (rx_valid),
    .en      (state != S_IDLE),
    .expired (tmo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A received byte always takes priority over a coincident timeout expiry.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    latch_n   = 1'b0;
    take      = 1'b0;
    word_done = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          start     = 1'b1;
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_valid) begin
          latch_n   = 1'b1;
          state_nxt = S_DATA;
        end else if (tmo) begin
          frame_bad = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          take = 1'b1;
          if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
            word_done = 1'b1;
            if (words_left == 9'd1) state_nxt = S_CSUM;
          end
        end else if (tmo) begin
          frame_bad = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          frame_ok  = (rx_data == csum);
          frame_bad = (rx_data != csum);
          state_nxt = S_IDLE;
        end else if (tmo) begin
          frame_bad = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx   <= '0;
      words_left <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      word_sh    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we   <= word_done;
      load_done <= frame_ok;
      if (start) begin
        cpu_hold   <= 1'b1;
        load_error <= 1'b0;
        word_idx   <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
      end
      if (latch_n) words_left <= frame_words(rx_data);
      if (take) begin
        word_sh  <= {word_sh[15:0], rx_data};
        csum     <= csum ^ rx_data;
        byte_cnt <= byte_cnt + 2'd1;
      end
      // Write is presented the cycle after the 4th byte; word_idx wraps naturally.
      if (word_done) begin
        imem_addr  <= 32'({word_idx, 2'b00});
        imem_wdata <= {word_sh, rx_data};
        word_idx   <= word_idx + 1'b1;
        words_left <= words_left - 9'd1;
      end
      if (frame_ok)  cpu_hold   <= 1'b0;
      if (frame_bad) begin
        load_error <= 1'b1;
        byte_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frame loads, checksum/timeout errors,
// full 256-word image, back-to-back bytes and mid-frame reset.
module tb_imem_uart_loader;

  localparam int TC = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;

  imem_uart_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TC)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (load_done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word_frame(input logic [31:0] w, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    send_byte(cs);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_chk++; if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    n_chk++; if (imem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we got %b want 0", imem_we); end
    n_chk++; if (load_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", load_done); end
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", load_error); end
    n_chk++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got addr %h data %h want 0 0", imem_addr, imem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] pl[4];
    clear_log();
    pl = '{8'h20, 8'h1d, 8'h04, 8'h00};
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(pl[i]);
    n_chk++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL single_latency we got %b want 1", imem_we); end
    n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL single_hold_before got %b want 1", cpu_hold); end
    send_byte(8'h39);
    repeat (2) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL single_nwr got %0d want 1", wr_addr_q.size()); end
    else begin
      n_chk++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h201d0400) begin
        n_fail++; $display("FAIL single_wr got %h/%h want 00000000/201d0400", wr_addr_q[0], wr_data_q[0]);
      end
    end
    n_chk++; if (done_cnt != 1)      begin n_fail++; $display("FAIL single_done got %0d want 1", done_cnt); end
    n_chk++; if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL single_hold_after got %b want 0", cpu_hold); end
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", load_error); end
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[3];
    clear_log();
    w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    send_byte(8'hA5);
    n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reload_hold got %b want 1", cpu_hold); end
    send_byte(8'h03);
    for (int i = 0; i < 3; i++)
      for (int j = 3; j >= 0; j--) send_byte(w[i][j*8 +: 8]);
    send_byte(8'h33);  // good checksum would be CC
    repeat (2) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL bad_nwr got %0d want 3", wr_addr_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (wr_addr_q[i] !== 32'(i*4) || wr_data_q[i] !== w[i]) begin
          n_fail++; $display("FAIL bad_wr%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 32'(i*4), w[i]);
        end
      end
    end
    n_chk++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL bad_err got %b want 1", load_error); end
    n_chk++; if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL bad_hold got %b want 1", cpu_hold); end
    n_chk++; if (done_cnt != 0)       begin n_fail++; $display("FAIL bad_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_timeout();
    int waited;
    clear_log();
    send_byte(8'hA5);
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_err got %b want 0", load_error); end
    send_byte(8'h02);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (TC - 3) @(negedge clk);
    n_chk++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", load_error); end
    waited = 0;
    while (load_error !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    n_chk++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1 (bound expired)", load_error); end
    repeat (3) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL tmo_nwr got %0d want 1", wr_addr_q.size()); end
    else begin
      n_chk++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h01020304) begin
        n_fail++; $display("FAIL tmo_wr got %h/%h want 00000000/01020304", wr_addr_q[0], wr_data_q[0]);
      end
    end
    // Back in IDLE: a fresh frame must load cleanly from address 0.
    clear_log();
    send_word_frame(32'h201d0400, 8'h39);
    repeat (2) @(negedge clk);
    n_chk++; if (done_cnt != 1 || wr_addr_q.size() != 1) begin
      n_fail++; $display("FAIL tmo_recover got done %0d writes %0d want 1 1", done_cnt, wr_addr_q.size());
    end
  endtask

  task automatic test_full();
    int bad_cnt;
    logic [31:0] w;
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      w = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8]);
    end
    send_byte(8'h00);  // every word XORs to 00
    repeat (2) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 256) begin n_fail++; $display("FAIL full_nwr got %0d want 256", wr_addr_q.size()); end
    else begin
      n_chk++; if (wr_addr_q[255] !== 32'h3FC) begin n_fail++; $display("FAIL full_last_addr got %h want 000003fc", wr_addr_q[255]); end
      bad_cnt = 0;
      for (int i = 0; i < 256; i++)
        if (wr_addr_q[i] !== 32'(i*4) || wr_data_q[i] !== {8'hA5, 8'(i), 8'h5A, ~8'(i)}) bad_cnt++;
      n_chk++; if (bad_cnt != 0) begin n_fail++; $display("FAIL full_words got %0d bad want 0", bad_cnt); end
    end
    n_chk++; if (done_cnt != 1)     begin n_fail++; $display("FAIL full_done got %0d want 1", done_cnt); end
    n_chk++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL full_hold got %b want 0", cpu_hold); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fb[15];
    logic       exp_we;
    logic [31:0] w[3];
    clear_log();
    fb = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
           8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
    w  = '{32'h01020304, 32'hA5A5A5A5, 32'hDEADBEEF};
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_we = (k - 1 >= 2) && (k - 1 <= 13) && (((k - 1 - 2) % 4) == 3);
        n_chk++; if (imem_we !== exp_we) begin
          n_fail++; $display("FAIL b2b_we after byte %0d got %b want %b", k - 1, imem_we, exp_we);
        end
      end
      if (k < 15) begin rx_data = fb[k]; rx_valid = 1'b1; end
      else rx_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL b2b_nwr got %0d want 3", wr_addr_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (wr_addr_q[i] !== 32'(i*4) || wr_data_q[i] !== w[i]) begin
          n_fail++; $display("FAIL b2b_wr%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 32'(i*4), w[i]);
        end
      end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rx_data = 8'h44; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_chk++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL mid_pre_we got %b want 1", imem_we); end
    reset = 1'b1;
    #1;
    n_chk++; if (imem_we !== 1'b0)  begin n_fail++; $display("FAIL mid_we got %b want 0", imem_we); end
    n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold got %b want 1", cpu_hold); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    send_word_frame(32'hCAFEF00D, 8'hC9);
    repeat (2) @(negedge clk);
    n_chk++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL mid_nwr got %0d want 1", wr_addr_q.size()); end
    else begin
      n_chk++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'hCAFEF00D) begin
        n_fail++; $display("FAIL mid_wr got %h/%h want 00000000/cafef00d", wr_addr_q[0], wr_data_q[0]);
      end
    end
    n_chk++; if (done_cnt != 1 || cpu_hold !== 1'b0) begin
      n_fail++; $display("FAIL mid_done got done %0d hold %b want 1 0", done_cnt, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_csum();
    test_timeout();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
